// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: a shift register of in-flight register writes that supplies bypass
// data per read port from the youngest matching entry and flags load-use hazards.
module forward_scoreboard #(
    parameter int NREAD  = 2,
    parameter int NSTAGE = 3,
    parameter int DW     = 32,
    parameter int RW     = 5
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                advance,
    input  logic                flush,
    input  logic                ex_regWEN,
    input  logic [RW-1:0]       ex_wsel,
    input  logic                ex_rdy,
    input  logic [DW-1:0]       ex_wdat,
    input  logic                ld_fill,
    input  logic [DW-1:0]       ld_wdat,
    input  logic [NREAD*RW-1:0] rd_sel,
    output logic [NREAD-1:0]    fwd_hit,
    output logic [NREAD*DW-1:0] fwd_dat,
    output logic                hazard,
    output logic [15:0]         stall_cnt
);

    logic [NSTAGE-1:0] vld_reg;
    logic [NSTAGE-1:0] rdy_reg;
    logic [RW-1:0]     wsel_reg [NSTAGE];
    logic [DW-1:0]     dat_reg  [NSTAGE];
    logic [15:0]       stall_cnt_reg;
    logic [NREAD-1:0]  port_haz;

    // A fill only lands on a valid entry that is still waiting for its data.
    logic          fill_ok;
    logic          e0_rdy_next;
    logic [DW-1:0] e0_dat_next;

    assign fill_ok     = ld_fill & vld_reg[0] & ~rdy_reg[0];
    assign e0_rdy_next = rdy_reg[0] | fill_ok;
    assign e0_dat_next = fill_ok ? ld_wdat : dat_reg[0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_reg <= '0;
            rdy_reg <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                wsel_reg[i] <= '0;
                dat_reg[i]  <= '0;
            end
        end else if (advance) begin
            vld_reg[0]  <= ex_regWEN & ~flush & (ex_wsel != '0);
            wsel_reg[0] <= ex_wsel;
            rdy_reg[0]  <= ex_rdy;
            dat_reg[0]  <= ex_wdat;
            // The filled view of entry 0 is what moves down, so a same-cycle fill is not lost.
            for (int i = 1; i < NSTAGE; i++) begin
                vld_reg[i]  <= vld_reg[i-1];
                wsel_reg[i] <= wsel_reg[i-1];
                rdy_reg[i]  <= (i == 1) ? e0_rdy_next : rdy_reg[i-1];
                dat_reg[i]  <= (i == 1) ? e0_dat_next : dat_reg[i-1];
            end
        end else begin
            rdy_reg[0] <= e0_rdy_next;
            dat_reg[0] <= e0_dat_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
            logic [RW-1:0] sel;
            logic          win_found;
            logic          win_rdy;
            logic [DW-1:0] win_dat;

            assign sel = rd_sel[gi*RW +: RW];

            // Scan oldest to youngest so the youngest match overwrites the winner last.
            always_comb begin
                win_found = 1'b0;
                win_rdy   = 1'b0;
                win_dat   = '0;
                for (int i = NSTAGE - 1; i >= 0; i--) begin
                    if (vld_reg[i] && (wsel_reg[i] == sel) && (sel != '0)) begin
                        win_found = 1'b1;
                        win_rdy   = rdy_reg[i];
                        win_dat   = dat_reg[i];
                    end
                end
            end

            assign fwd_hit[gi]            = win_found & win_rdy;
            assign fwd_dat[gi*DW +: DW]   = (win_found & win_rdy) ? win_dat : '0;
            assign port_haz[gi]           = win_found & ~win_rdy;
        end
    endgenerate

    assign hazard = |port_haz;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_reg <= '0;
        end else if (hazard && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule
